// File: rtl/iq_pkg.sv
// iq_pkg: types and constants shared by the IQ sample writer and reader.
//   iq_state_t : writer FSM states (READ = collect one I/Q pair, WRITE = push packed word)
//   SAMPLE_MAX : largest packed component value (saturation ceiling)
//   SAMPLE_MIN : smallest packed component value (saturation floor)
package iq_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } iq_state_t;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/iq_write_if.sv
// iq_write_if: FIFO-side bus of iq_write.
//   i_data_in/i_empty/i_rd_en : show-ahead I sample FIFO
//   q_data_in/q_empty/q_rd_en : show-ahead Q sample FIFO
//   out_dout/out_full/out_wr_en : packed IQ word output FIFO
// master = the writer block, slave = the FIFOs around it.
interface iq_write_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_data_in;
    logic                  i_empty;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] q_data_in;
    logic                  q_empty;
    logic                  q_rd_en;
    logic [DATA_WIDTH-1:0] out_dout;
    logic                  out_full;
    logic                  out_wr_en;

    modport master (
        input  i_data_in, i_empty, q_data_in, q_empty, out_full,
        output i_rd_en, q_rd_en, out_dout, out_wr_en
    );

    modport slave (
        output i_data_in, i_empty, q_data_in, q_empty, out_full,
        input  i_rd_en, q_rd_en, out_dout, out_wr_en
    );
endinterface

// File: rtl/iq_dequant.sv
// iq_dequant: combinational dequantizer for one fixed-point component.
//   x      : signed sample with QUANTIZE_WIDTH fractional bits
//   sample : x rounded half-up to an integer, saturated to SAMPLE_WIDTH bits
//   sat    : high when the saturation limit was applied
module iq_dequant
    import iq_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int QUANTIZE_WIDTH = 10,
    parameter int SAMPLE_WIDTH   = 16
) (
    input  logic [DATA_WIDTH-1:0]   x,
    output logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    sat
);
    // One extra bit so adding the rounding constant to the most positive
    // input cannot overflow.
    localparam int W = DATA_WIDTH + 1;
    localparam logic signed [W-1:0] HALF =
        {{(W-QUANTIZE_WIDTH){1'b0}}, 1'b1, {(QUANTIZE_WIDTH-1){1'b0}}};
    localparam logic signed [W-1:0] R_MAX =
        {{(W-SAMPLE_WIDTH){SAMPLE_MAX[SAMPLE_WIDTH-1]}}, SAMPLE_MAX};
    localparam logic signed [W-1:0] R_MIN =
        {{(W-SAMPLE_WIDTH){SAMPLE_MIN[SAMPLE_WIDTH-1]}}, SAMPLE_MIN};

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] rounded;
    logic signed [W-1:0] r;

    assign x_ext   = {x[DATA_WIDTH-1], x};
    assign rounded = x_ext + HALF;
    assign r       = rounded >>> QUANTIZE_WIDTH;

    always_comb begin
        sample = r[SAMPLE_WIDTH-1:0];
        sat    = 1'b0;
        if (r > R_MAX) begin
            sample = SAMPLE_MAX;
            sat    = 1'b1;
        end else if (r < R_MIN) begin
            sample = SAMPLE_MIN;
            sat    = 1'b1;
        end
    end
endmodule

// File: rtl/iq_write.sv
// iq_write: pops one I and one Q sample together, dequantizes both and
// pushes the packed word {Q[15:0], I[15:0]} to the output FIFO.
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-low
//   bus       : I/Q input FIFOs and output FIFO (iq_write_if.master)
//   sat_count : packed words with at least one saturated component,
//               sticks at 0xFFFF
// Peak rate is one word every 2 cycles (pop in READ, push in WRITE).
module iq_write
    import iq_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int QUANTIZE_WIDTH = 10,
    parameter int SAMPLE_WIDTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    iq_write_if.master  bus,
    output logic [15:0] sat_count
);
    iq_state_t               state;
    logic [SAMPLE_WIDTH-1:0] i_sample, q_sample;
    logic                    i_sat, q_sat;
    logic                    pop;

    iq_dequant #(
        .DATA_WIDTH    (DATA_WIDTH),
        .QUANTIZE_WIDTH(QUANTIZE_WIDTH),
        .SAMPLE_WIDTH  (SAMPLE_WIDTH)
    ) u_deq_i (
        .x     (bus.i_data_in),
        .sample(i_sample),
        .sat   (i_sat)
    );

    iq_dequant #(
        .DATA_WIDTH    (DATA_WIDTH),
        .QUANTIZE_WIDTH(QUANTIZE_WIDTH),
        .SAMPLE_WIDTH  (SAMPLE_WIDTH)
    ) u_deq_q (
        .x     (bus.q_data_in),
        .sample(q_sample),
        .sat   (q_sat)
    );

    // Both FIFOs share one pop so I and Q can never drift apart.
    assign pop           = (state == READ) && !bus.i_empty && !bus.q_empty;
    assign bus.i_rd_en   = pop;
    assign bus.q_rd_en   = pop;
    // Full is sampled combinationally; the push retries every cycle.
    assign bus.out_wr_en = (state == WRITE) && !bus.out_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= READ;
            bus.out_dout <= '0;
            sat_count    <= '0;
        end else begin
            if (state == READ) begin
                if (pop) begin
                    bus.out_dout <= {q_sample, i_sample};
                    state        <= WRITE;
                    if ((i_sat || q_sat) && (sat_count != 16'hFFFF))
                        sat_count <= sat_count + 16'd1;
                end
            end else begin
                if (!bus.out_full)
                    state <= READ;
            end
        end
    end
endmodule

// File: tb/tb_iq_write.sv
module tb_iq_write;
    logic        clock;
    logic        reset;
    logic [15:0] sat_count;
    int          vecs = 0;
    int          errs = 0;
    int          cyc  = 0;
    logic [15:0] m_sat = 16'd0;
    int          last_push = 0;

    iq_write_if #(.DATA_WIDTH(32)) bus ();

    iq_write #(
        .DATA_WIDTH    (32),
        .QUANTIZE_WIDTH(10),
        .SAMPLE_WIDTH  (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .sat_count(sat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference dequantizer: integer round-half-up then clamp.
    function automatic logic [15:0] dq(input logic [31:0] x, output bit s);
        longint r;
        r = (longint'($signed(x)) + 512) >>> 10;
        s = 1'b0;
        if (r > 32767) begin
            s = 1'b1;
            return 16'h7FFF;
        end
        if (r < -32768) begin
            s = 1'b1;
            return 16'h8000;
        end
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the FSM in READ.
    task automatic push_pair(input logic [31:0] iv, input logic [31:0] qv,
                             input int full_cyc, input int unbal);
        logic [15:0] a, b;
        logic [31:0] exp;
        bit          si, sq;
        bus.i_data_in = iv;
        bus.q_data_in = qv;
        bus.i_empty   = 1'b0;
        bus.q_empty   = (unbal > 0);
        bus.out_full  = 1'b0;
        for (int k = 0; k < unbal; k++) begin
            #1;
            chk("unbal_i_rd_en", 32'(bus.i_rd_en), 32'd0);
            chk("unbal_q_rd_en", 32'(bus.q_rd_en), 32'd0);
            @(posedge clock); #1;
        end
        bus.q_empty = 1'b0;
        #1;
        chk("pop_i_rd_en", 32'(bus.i_rd_en), 32'd1);
        chk("pop_q_rd_en", 32'(bus.q_rd_en), 32'd1);
        a   = dq(iv, si);
        b   = dq(qv, sq);
        exp = {b, a};
        if ((si || sq) && m_sat != 16'hFFFF) m_sat++;
        @(posedge clock); #1;
        bus.i_empty  = 1'b1;
        bus.q_empty  = 1'b1;
        bus.out_full = (full_cyc > 0);
        for (int k = 0; k < full_cyc; k++) begin
            #1;
            chk("full_wr_en", 32'(bus.out_wr_en), 32'd0);
            chk("full_dout", bus.out_dout, exp);
            chk("full_no_pop", 32'(bus.i_rd_en | bus.q_rd_en), 32'd0);
            @(posedge clock); #1;
        end
        bus.out_full = 1'b0;
        #1;
        chk("push_wr_en", 32'(bus.out_wr_en), 32'd1);
        chk("push_dout", bus.out_dout, exp);
        chk("sat_count", 32'(sat_count), 32'(m_sat));
        last_push = cyc;
        @(posedge clock); #1;
    endtask

    initial begin
        int p;
        logic [31:0] iv, qv;
        bus.i_data_in = '0;
        bus.q_data_in = '0;
        bus.i_empty   = 1'b1;
        bus.q_empty   = 1'b1;
        bus.out_full  = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_dout", bus.out_dout, 32'h0);
        chk("rst_sat", 32'(sat_count), 32'h0);
        chk("rst_wr_en", 32'(bus.out_wr_en), 32'd0);
        chk("rst_rd_en", 32'(bus.i_rd_en | bus.q_rd_en), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Unit values plus literal expectations for the rounding corners.
        push_pair(32'h0000_0400, 32'hFFFF_FC00, 0, 0);
        chk("unit_dout_lit", bus.out_dout, 32'hFFFF_0001);
        push_pair(32'h0000_0200, 32'h0, 0, 0);
        chk("round_half_up", bus.out_dout, 32'h0000_0001);
        push_pair(32'hFFFF_FE00, 32'h0, 0, 0);
        chk("round_neg_half", bus.out_dout, 32'h0000_0000);
        push_pair(32'h0000_01FF, 32'h0, 0, 0);
        chk("round_below_half", bus.out_dout, 32'h0000_0000);

        // Saturation both ways.
        push_pair(32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
        chk("sat_dout_lit", bus.out_dout, 32'h8000_7FFF);
        chk("sat_count_one", 32'(sat_count), 32'd1);

        // Backpressure for 3 cycles, then unbalanced inputs for 5 cycles.
        push_pair(32'h0012_3456, 32'hFFED_CBA9, 3, 0);
        push_pair(32'h0000_0C00, 32'h0000_1000, 0, 5);

        // Counter ceiling: preload near the top, then saturate past it.
        force dut.sat_count = 16'hFFFE;
        #1;
        release dut.sat_count;
        m_sat = 16'hFFFE;
        push_pair(32'h7FFF_0000, 32'h0, 0, 0);
        chk("sat_ceiling", 32'(sat_count), 32'hFFFF);
        push_pair(32'h0, 32'h9000_0000, 0, 0);
        chk("sat_sticky", 32'(sat_count), 32'hFFFF);

        // Randomized pairs with random backpressure.
        for (int n = 0; n < 40; n++) begin
            iv = $urandom;
            qv = $urandom;
            case ($urandom_range(0, 2))
                0: ;
                1: begin
                    iv = 32'($urandom_range(0, 67108863)) - 32'h0200_0000;
                    qv = 32'($urandom_range(0, 67108863)) - 32'h0200_0000;
                end
                default: begin
                    iv = 32'h01FF_FE00 + 32'($urandom_range(0, 2047)) - 32'd1024;
                    qv = 32'hFDFF_FE00 + 32'($urandom_range(0, 2047)) - 32'd1024;
                end
            endcase
            push_pair(iv, qv, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
        end

        // Reset in the middle of WRITE drops the pending word.
        bus.i_data_in = 32'h7FFF_FFFF;
        bus.q_data_in = 32'h0000_0400;
        bus.i_empty   = 1'b0;
        bus.q_empty   = 1'b0;
        @(posedge clock); #1;
        bus.i_empty  = 1'b1;
        bus.q_empty  = 1'b1;
        bus.out_full = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        bus.out_full = 1'b0;
        #1;
        chk("midrst_dout", bus.out_dout, 32'h0);
        chk("midrst_sat", 32'(sat_count), 32'h0);
        chk("midrst_wr_en", 32'(bus.out_wr_en), 32'd0);
        m_sat = 16'd0;
        @(posedge clock); #1;
        chk("midrst_hold_wr_en", 32'(bus.out_wr_en), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_idle", 32'(bus.out_wr_en | bus.i_rd_en), 32'd0);

        // Back-to-back stream of 8 pairs: one word every 2 cycles.
        p = 0;
        for (int n = 0; n < 8; n++) begin
            push_pair($urandom, $urandom, 0, 0);
            if (n > 0) chk("stream_rate", 32'(last_push - p), 32'd2);
            p = last_push;
        end
        chk("stream_end_idle", 32'(bus.out_wr_en | bus.i_rd_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
